// File: rtl/spi_sat_pkg.sv
// Shared types and default sizing for the SPI satellite arbiter.
package spi_sat_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int TX_LEN_DEF = 1;
    localparam int RX_LEN_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_DONE
    } sat_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of req_i scanning upward from last_i+1.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = '0;
        for (int k = 1; k <= N; k++) begin
            j = IW'((int'(last_i) + k) % N);
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                idx_o    = j;
                gnt_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_sat_arb.sv
// Round-robin arbiter sharing one SPI engine among N_REQ requesters.
// One transfer in flight at a time: IDLE -> LAUNCH -> WAIT -> DONE.
module spi_sat_arb
    import spi_sat_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int TX_LEN = TX_LEN_DEF,
    parameter int RX_LEN = RX_LEN_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_REQ-1:0]                    req_valid,
    input  logic [N_REQ-1:0][TX_LEN*8-1:0]      req_cmd,
    output logic [N_REQ-1:0]                    req_ready,
    output logic [N_REQ-1:0]                    rsp_valid,
    output logic [RX_LEN*8-1:0]                 rsp_data,
    input  logic [N_REQ-1:0]                    req_en,
    output logic                                busy,
    output logic [$clog2(N_REQ)-1:0]            grant_id,
    output logic [TX_LEN*8-1:0]                 sat_cmd,
    output logic                                sat_trmt,
    input  logic [RX_LEN*8-1:0]                 sat_resp,
    input  logic                                sat_rx_rdy,
    output logic                                sat_clr_rdy
);

    localparam int GW = $clog2(N_REQ);

    sat_state_e              state_q;
    logic [GW-1:0]           last_q;
    logic [GW-1:0]           grant_q;
    logic [TX_LEN*8-1:0]     cmd_q;
    logic [RX_LEN*8-1:0]     rsp_q;
    logic                    first_q;

    logic [N_REQ-1:0]        elig;
    logic [N_REQ-1:0]        gnt_oh;
    logic [GW-1:0]           gnt_idx;
    logic                    gnt_any;
    logic                    rx_hit;

    assign elig = req_valid & req_en;

    rr_arbiter #(.N(N_REQ), .IW(GW)) u_arb (
        .req_i  (elig),
        .last_i (last_q),
        .gnt_o  (gnt_oh),
        .idx_o  (gnt_idx),
        .any_o  (gnt_any)
    );

    // The first WAIT cycle is blind: the engine may still show the previous done flag.
    assign rx_hit = (state_q == ST_WAIT) && !first_q && sat_rx_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= GW'(N_REQ - 1);
            grant_q <= '0;
            cmd_q   <= '0;
            rsp_q   <= '0;
            first_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_any) begin
                        grant_q <= gnt_idx;
                        cmd_q   <= req_cmd[gnt_idx];
                        state_q <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    first_q <= 1'b1;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    first_q <= 1'b0;
                    if (rx_hit) begin
                        rsp_q   <= sat_resp;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    last_q  <= grant_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == ST_IDLE) ? gnt_oh : '0;
    assign rsp_valid   = (state_q == ST_DONE) ? (N_REQ'(1) << grant_q) : '0;
    assign rsp_data    = rsp_q;
    assign busy        = (state_q != ST_IDLE);
    assign grant_id    = grant_q;
    assign sat_cmd     = cmd_q;
    assign sat_trmt    = (state_q == ST_LAUNCH);
    assign sat_clr_rdy = rx_hit;

endmodule

// File: tb/tb_spi_sat_arb.sv
// Bench for spi_sat_arb: engine model plus a transaction-level expectation model.
module tb_spi_sat_arb;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid, req_en, req_ready, rsp_valid;
    logic [N-1:0][7:0] req_cmd;
    logic [7:0]       rsp_data, sat_cmd, sat_resp;
    logic             busy, sat_trmt, sat_rx_rdy, sat_clr_rdy;
    logic [1:0]       grant_id;

    spi_sat_arb #(.N_REQ(N), .TX_LEN(1), .RX_LEN(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .req_en(req_en), .busy(busy), .grant_id(grant_id), .sat_cmd(sat_cmd),
        .sat_trmt(sat_trmt), .sat_resp(sat_resp), .sat_rx_rdy(sat_rx_rdy),
        .sat_clr_rdy(sat_clr_rdy)
    );

    always #5 clk = ~clk;

    int npass = 0, nfail = 0, cyc = 0;
    // requesters
    bit         pend [N];
    logic [7:0] pcmd [N];
    logic [N-1:0] en_mask;
    bit         rearm;
    // engine model
    int eng_wait, eng_x, stale_left;
    bit eng_rdy, rand_eng, stale_mode;
    logic [7:0] eng_val;
    // expectation model
    int m_owner, m_last, m_acc, m_det, m_gid;
    logic [7:0] m_cmdq, m_rsp, m_pend;
    // observed history
    int grants[$], rsps[$];
    int dut_acc, lat_last, trmt_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] e, input int last);
        for (int k = 1; k <= N; k++)
            if (e[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic drive();
        cyc++;
        if (stale_left > 0) begin
            stale_left--;
            if (stale_left == 0) eng_rdy = 1'b0;
        end
        if (eng_wait > 0) begin
            eng_wait--;
            if (eng_wait == 0) begin
                eng_rdy  = 1'b1;
                sat_resp = eng_val;
            end
        end
        sat_rx_rdy = eng_rdy;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pend[i];
            req_cmd[i]   = pcmd[i];
        end
        req_en = en_mask;
    endtask

    task automatic sample();
        logic [N-1:0] elig, exp_ready, exp_rspv;
        logic exp_trmt, exp_clr, exp_busy;
        int g;
        if (rst) begin
            m_owner = -1; m_last = N - 1; m_det = -1; m_gid = 0;
            m_cmdq = '0; m_rsp = '0;
            eng_rdy = 1'b0; eng_wait = 0; stale_left = 0;
            return;
        end
        elig      = req_valid & en_mask;
        exp_ready = '0;
        exp_rspv  = '0;
        g         = -1;
        exp_trmt  = (m_owner >= 0) && (cyc == m_acc + 1);
        exp_busy  = (m_owner >= 0) && (cyc > m_acc);
        exp_clr   = (m_owner >= 0) && (m_det < 0) && (cyc >= m_acc + 3) && eng_rdy;
        if (m_owner >= 0 && m_det >= 0 && cyc == m_det + 1) begin
            exp_rspv[m_owner] = 1'b1;
            m_rsp = m_pend;
        end
        if (m_owner < 0) begin
            g = rr_pick(elig, m_last);
            if (g >= 0) exp_ready[g] = 1'b1;
        end
        chk("req_ready", req_ready, exp_ready);
        chk("rsp_valid", rsp_valid, exp_rspv);
        chk("sat_trmt", sat_trmt, exp_trmt);
        chk("sat_clr_rdy", sat_clr_rdy, exp_clr);
        chk("busy", busy, exp_busy);
        chk("grant_id", grant_id, m_gid);
        chk("sat_cmd", sat_cmd, m_cmdq);
        chk("rsp_data", rsp_data, m_rsp);
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] === 1'b1) begin grants.push_back(i); dut_acc = cyc; end
            if (rsp_valid[i] === 1'b1) begin rsps.push_back(i); lat_last = cyc - dut_acc + 1; end
        end
        if (sat_trmt === 1'b1) begin
            trmt_cnt++;
            eng_wait = (rand_eng ? int'($urandom_range(5, 1)) : eng_x) + 1;
            if (rand_eng) eng_val = 8'($urandom);
            if (stale_mode) stale_left = 2;
        end
        if (sat_clr_rdy === 1'b1) eng_rdy = 1'b0;
        if (exp_clr) begin m_det = cyc; m_pend = sat_resp; end
        if (exp_rspv != '0) begin m_last = m_owner; m_owner = -1; m_det = -1; end
        if (g >= 0) begin
            m_owner = g; m_acc = cyc; m_gid = g; m_cmdq = pcmd[g];
            pend[g] = 1'b0;
            if (rearm) begin pend[g] = 1'b1; pcmd[g] = 8'($urandom); end
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        drive();
        @(negedge clk);
        sample();
    endtask

    task automatic wait_rsp(input int target, input string tag);
        for (int n = 0; n < 300 && rsps.size() < target; n++) step();
        chk(tag, rsps.size(), target);
    endtask

    task automatic drain();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        rearm = 1'b0;
        for (int n = 0; n < 100 && m_owner >= 0; n++) step();
        step();
    endtask

    int exp38[5] = '{0, 1, 2, 3, 0};
    int exp40[4] = '{0, 1, 3, 0};
    int g0, r0, t0;

    initial begin
        rst = 1'b1; req_valid = '0; req_cmd = '0; req_en = '0;
        sat_resp = '0; sat_rx_rdy = 1'b0;
        en_mask = '1; rearm = 1'b0; rand_eng = 1'b0; stale_mode = 1'b0;
        eng_wait = 0; eng_rdy = 1'b0; stale_left = 0; eng_x = 2; eng_val = '0;
        trmt_cnt = 0; dut_acc = 0; lat_last = 0; m_pend = '0; m_acc = 0;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pcmd[i] = '0; end

        // reset and idle state
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_id", grant_id, 2'd0);
        chk("rst_rsp_data", rsp_data, 8'h00);

        // all four requesting: 0,1,2,3,0
        g0 = grants.size(); r0 = rsps.size();
        rearm = 1'b1;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b1; pcmd[i] = 8'($urandom); end
        wait_rsp(r0 + 5, "rr_timeout");
        for (int i = 0; i < 5; i++) begin
            chk("rr_grant", grants[g0 + i], exp38[i]);
            chk("rr_rsp", rsps[r0 + i], exp38[i]);
        end
        drain();

        // single request on 2, engine answers 3C
        r0 = rsps.size(); t0 = trmt_cnt;
        eng_x = 3; eng_val = 8'h3C;
        pend[2] = 1'b1; pcmd[2] = 8'hA5;
        wait_rsp(r0 + 1, "single_timeout");
        chk("single_trmt_cnt", trmt_cnt - t0, 1);
        chk("single_rsp_idx", rsps[r0], 2);
        chk("single_rsp_data", rsp_data, 8'h3C);
        chk("single_latency", lat_last, eng_x + 4);
        drain();

        // requester 2 masked off
        rst = 1'b1; step(); rst = 1'b0;
        g0 = grants.size(); r0 = rsps.size();
        en_mask = 4'b1011; eng_x = 1; rearm = 1'b1;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b1; pcmd[i] = 8'($urandom); end
        wait_rsp(r0 + 4, "mask_timeout");
        for (int i = 0; i < 4; i++) chk("mask_grant", grants[g0 + i], exp40[i]);
        drain();
        en_mask = '1;

        // stale done flag held through LAUNCH and first WAIT
        r0 = rsps.size();
        eng_rdy = 1'b1; sat_resp = 8'hEE; stale_mode = 1'b1;
        eng_x = 4; eng_val = 8'h5A;
        pend[1] = 1'b1; pcmd[1] = 8'h77;
        wait_rsp(r0 + 1, "stale_timeout");
        stale_mode = 1'b0;
        chk("stale_rsp_data", rsp_data, 8'h5A);
        chk("stale_latency", lat_last, eng_x + 4);
        drain();

        // reset in the middle of WAIT abandons the transfer
        r0 = rsps.size();
        eng_x = 6; pend[3] = 1'b1; pcmd[3] = 8'h31;
        for (int n = 0; n < 50 && !(m_owner >= 0 && cyc >= m_acc + 4); n++) step();
        chk("midrst_in_wait", busy, 1'b1);
        rst = 1'b1; step(); rst = 1'b0;
        step();
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rsp_valid", rsp_valid, 4'b0000);
        eng_x = 2; pend[1] = 1'b1; pcmd[1] = 8'hC4;
        wait_rsp(r0 + 1, "midrst_timeout");
        chk("midrst_rsp_idx", rsps[r0], 1);
        drain();

        // randomized traffic
        rand_eng = 1'b1;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(3, 0) == 0) begin
                    pend[i] = 1'b1; pcmd[i] = 8'($urandom);
                end else if (pend[i] && $urandom_range(39, 0) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            if ($urandom_range(15, 0) == 0) en_mask = 4'($urandom);
            step();
        end
        en_mask = '1;
        for (int n = 0; n < 400 && (pend[0] || pend[1] || pend[2] || pend[3] || m_owner >= 0); n++)
            step();
        chk("rand_drained", m_owner < 0, 1'b1);
        drain();

        $display("%0d/%0d checks passed", npass, npass + nfail);
        $finish;
    end

endmodule
